map_table_restore_ctrl: RTL and testbench
=========================================

# map_table_restore_ctrl

Sequencer and write-port arbiter for the 10-read/5-write rename map-table SRAM. It owns the table's five write ports. In normal operation it passes rename writes through to those ports. On a recovery request it takes over all five ports and copies the architectural map table into the speculative map table, five entries per cycle, holding rename stalled until the copy completes.

## Interface
- SRAM_DEPTH, 64: map-table entries.
- SRAM_INDEX, 6: log2(SRAM_DEPTH).
- SRAM_WIDTH, 8: physical-tag width per entry.
- NUM_WR, 5: write ports, which is also the restore lanes per cycle.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- recover_i  in  1  start a restore; sampled each cycle.
- ren_we_i  in  NUM_WR  rename write enables, lane k = bit k.
- ren_addr_i  in  NUM_WR*SRAM_INDEX  rename binary write index, lane k = bits [k*SRAM_INDEX +: SRAM_INDEX].
- ren_data_i  in  NUM_WR*SRAM_WIDTH  rename write data.
- amt_rd_addr_o  out  NUM_WR*SRAM_DEPTH  one-hot read addresses to architectural table.
- amt_rd_data_i  in  NUM_WR*SRAM_WIDTH  combinational read data from architectural table.
- we_o  out  NUM_WR  write enables to speculative table.
- decoded_addrwr_o  out  NUM_WR*SRAM_DEPTH  one-hot write addresses.
- datawr_o  out  NUM_WR*SRAM_WIDTH  write data.
- busy_o  out  1  rename must stall.
- done_o  out  1  one-cycle pulse when a restore completes.
- restore_cnt_o  out  16  completed-restore count (see Configuration).

## Operation
- States: IDLE, RESTORE, DONE. Registered state; 2-bit encoding from the package.
- Pointer ptr: SRAM_INDEX+1 bits, registered; it is the base entry of the current restore group.
- IDLE/DONE, recover_i=0:
  - Lane k passes through: we_o[k]=ren_we_i[k].
  - decoded_addrwr_o lane k = one-hot(ren_addr_i lane k); datawr_o = ren_data_i.
  - amt_rd_addr_o = 0.
- IDLE/DONE, recover_i=1:
  - All we_o forced to 0; that cycle's rename writes are dropped.
  - Next state RESTORE; ptr <= 0.
- RESTORE, lane k:
  - entry e = ptr+k; valid when e < SRAM_DEPTH.
  - Valid lane: amt_rd_addr_o lane k = one-hot(e), decoded_addrwr_o lane k = one-hot(e), datawr_o lane k = amt_rd_data_i lane k, we_o[k]=1.
  - Invalid lane: that lane's amt_rd_addr_o, decoded_addrwr_o and datawr_o are all zero, and we_o[k]=0.
  - Rename inputs are ignored.
  - ptr <= ptr+NUM_WR.
  - When ptr+NUM_WR >= SRAM_DEPTH: next state DONE.
- RESTORE with recover_i=1: restart, ptr <= 0, stay in RESTORE. This cycle's restore writes still issue.
- DONE:
  - done_o=1 (registered, asserted only in DONE); one cycle, then IDLE.
  - Port muxing is as in IDLE.
- busy_o = recover_i | (state==RESTORE); combinational so rename stalls the same cycle.
- No two lanes ever target the same entry, so there is no write-port conflict inside the SRAM.

## Timing
- Reset (asynchronous, while reset=0): state=IDLE, ptr=0, done_o=0, restore_cnt_o=0. Combinational outputs follow IDLE rules.
- Reset mid-restore: abort immediately, with no done_o pulse. The table is left partially restored; the recovery owner must reissue recover_i.
- Restore length for recover_i at cycle 0:
  - RESTORE runs in cycles 1..ceil(SRAM_DEPTH/NUM_WR).
  - With the defaults that is cycles 1..13; cycle 13 writes entries 60..63, and lane 4 is idle.
  - DONE is in cycle 14.
- busy_o is high for cycles 0..13 and low in cycle 14; rename may write in the DONE cycle.
- Write latency is 0: outputs are combinational from inputs and state, and the SRAM captures them on the next edge.

## Configuration
- RESTORE_PERF_CNT_EN defined: restore_cnt_o is a 16-bit counter.
  - Increments on every cycle in DONE.
  - Saturates at 16'hFFFF.
- RESTORE_PERF_CNT_EN undefined: no counter flops; restore_cnt_o is tied to 0.

## Structure
- Shared package map_restore_pkg holds:
  - NUM_WR default.
  - State enum constants ST_IDLE=0, ST_RESTORE=1, ST_DONE=2.
  - Restore-counter width 16.
- Sub-module index_decoder (binary SRAM_INDEX to one-hot SRAM_DEPTH, with an enable input; output is zero when disabled).
  - Instantiated once per lane for the write path.
  - Restore lanes reuse the same decoder output through a muxed index.

## Test plan
- Reset, then rename lane 2 writes index 7, data 8'h3A with no recovery -> we_o=5'b00100; decoded_addrwr_o lane 2 = bit 7; datawr_o lane 2 = 8'h3A; busy_o=0.
- AMT preloaded with entry i = i+8'h40; pulse recover_i at cycle 0 -> busy_o high cycles 0..13. Cycle 1 writes entries 0..4 with 8'h40..8'h44; cycle 13 writes entries 60..63 with we_o=5'b01111. done_o=1 only in cycle 14. Speculative table then equals AMT.
- recover_i together with ren_we_i=5'b11111 in IDLE -> we_o=0 that cycle; no rename data lands in the table.
- recover_i reasserted in cycle 6 of a restore -> cycle 7 writes entries 0..4; done_o fires at cycle 20 only, one pulse.
- reset driven low in cycle 5 of a restore -> state IDLE asynchronously, done_o stays 0, and a later recover_i runs a full 13-cycle restore.
- With RESTORE_PERF_CNT_EN defined: three back-to-back restores -> restore_cnt_o=3. Undefined -> restore_cnt_o=0 throughout.

Source files
------------

// File: rtl/map_table_restore_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// map_restore_pkg
//   Shared constants and types for the rename map-table restore controller.
//   - NUM_WR_DEF     : default number of SRAM write ports / restore lanes.
//   - RESTORE_CNT_W  : width of the completed-restore counter output.
//   - restore_state_e: controller state encoding (2 bits).
// ---------------------------------------------------------------------------
package map_restore_pkg;

    localparam int NUM_WR_DEF    = 5;
    localparam int RESTORE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_DONE    = 2'd2
    } restore_state_e;

endpackage

// File: rtl/map_table_restore_ctrl_if.sv
// ---------------------------------------------------------------------------
// map_table_restore_ctrl_if
//   Bundle of every non-clock/reset signal of map_table_restore_ctrl.
//   Inputs : recover_i, ren_we_i, ren_addr_i, ren_data_i, amt_rd_data_i
//   Outputs: amt_rd_addr_o, we_o, decoded_addrwr_o, datawr_o, busy_o,
//            done_o, restore_cnt_o, state_o (debug view of the FSM state)
//   Modports: slave  - the controller itself
//             master - the rename / recovery / SRAM side
//
//   Handshake: there is no valid/ready pair. recover_i is a level sampled
//   every cycle; busy_o is combinational and tells rename to stall in the
//   same cycle; done_o is a single-cycle completion pulse.
// ---------------------------------------------------------------------------
interface map_table_restore_ctrl_if
    import map_restore_pkg::*;
#(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_WR     = NUM_WR_DEF
) ();

    logic                           recover_i;
    logic [NUM_WR-1:0]              ren_we_i;
    logic [NUM_WR*SRAM_INDEX-1:0]   ren_addr_i;
    logic [NUM_WR*SRAM_WIDTH-1:0]   ren_data_i;
    logic [NUM_WR*SRAM_DEPTH-1:0]   amt_rd_addr_o;
    logic [NUM_WR*SRAM_WIDTH-1:0]   amt_rd_data_i;
    logic [NUM_WR-1:0]              we_o;
    logic [NUM_WR*SRAM_DEPTH-1:0]   decoded_addrwr_o;
    logic [NUM_WR*SRAM_WIDTH-1:0]   datawr_o;
    logic                           busy_o;
    logic                           done_o;
    logic [RESTORE_CNT_W-1:0]       restore_cnt_o;
    restore_state_e                 state_o;

    modport slave (
        input  recover_i, ren_we_i, ren_addr_i, ren_data_i, amt_rd_data_i,
        output amt_rd_addr_o, we_o, decoded_addrwr_o, datawr_o,
               busy_o, done_o, restore_cnt_o, state_o
    );

    modport master (
        output recover_i, ren_we_i, ren_addr_i, ren_data_i, amt_rd_data_i,
        input  amt_rd_addr_o, we_o, decoded_addrwr_o, datawr_o,
               busy_o, done_o, restore_cnt_o, state_o
    );

endinterface

// File: rtl/map_table_restore_ctrl_index_decoder.sv
// ---------------------------------------------------------------------------
// index_decoder
//   Binary index to one-hot decoder with enable.
//   en_i     : when low the output is all zeros
//   index_i  : binary index (INDEX_W bits)
//   onehot_o : one-hot vector (DEPTH bits)
// ---------------------------------------------------------------------------
module index_decoder #(
    parameter int INDEX_W = 6,
    parameter int DEPTH   = 64
) (
    input  logic               en_i,
    input  logic [INDEX_W-1:0] index_i,
    output logic [DEPTH-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[index_i] = 1'b1;
        end
    end

endmodule

// File: rtl/map_table_restore_ctrl.sv
// ---------------------------------------------------------------------------
// map_table_restore_ctrl
//   Owns the five write ports of the rename map-table SRAM. Normally rename
//   writes pass straight through; on recover_i the controller copies the
//   architectural map table into the speculative table NUM_WR entries per
//   cycle while holding rename stalled via busy_o.
//
//   Ports:
//     clk   - clock, all state on the rising edge
//     reset - asynchronous, active-low reset
//     bus   - map_table_restore_ctrl_if.slave (rename inputs, AMT read
//             port, speculative-table write ports, busy/done/count/state)
//
//   Optional feature: define RESTORE_PERF_CNT_EN to build a saturating
//   16-bit counter of completed restores on restore_cnt_o; otherwise the
//   output is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module map_table_restore_ctrl
    import map_restore_pkg::*;
#(
    parameter int SRAM_DEPTH = 64,
    parameter int SRAM_INDEX = 6,
    parameter int SRAM_WIDTH = 8,
    parameter int NUM_WR     = NUM_WR_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    map_table_restore_ctrl_if.slave   bus
);

    // ptr holds group bases up to SRAM_DEPTH-1+NUM_WR; entry sums get one
    // extra bit so the "past the end" compare never wraps.
    localparam int PTR_W = SRAM_INDEX + 1;
    localparam int ENT_W = SRAM_INDEX + 2;

    restore_state_e         state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   restoring;
    logic [ENT_W-1:0]       grp_end;
    logic                   last_group;

    assign restoring  = (state_q == ST_RESTORE);
    assign grp_end    = ENT_W'(ptr_q) + ENT_W'(NUM_WR);
    assign last_group = (grp_end >= ENT_W'(SRAM_DEPTH));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.recover_i) begin
                    state_d = ST_RESTORE;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESTORE: begin
                // A new recovery restarts the copy from entry 0; the writes
                // issued this cycle are harmless since they get redone.
                if (bus.recover_i) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(NUM_WR);
                    if (last_group) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // ---------------- lane index mux ----------------
    // One decoder per lane serves both the rename write address and the
    // restore entry; in RESTORE the same one-hot also drives the AMT read.
    logic [ENT_W-1:0]       entry   [NUM_WR];
    logic [NUM_WR-1:0]      lane_ok;
    logic [SRAM_INDEX-1:0]  dec_idx [NUM_WR];
    logic [NUM_WR-1:0]      dec_en;
    logic [SRAM_DEPTH-1:0]  dec_oh  [NUM_WR];

    always_comb begin
        lane_ok = '0;
        dec_en  = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            entry[k]   = ENT_W'(ptr_q) + ENT_W'(k);
            lane_ok[k] = (entry[k] < ENT_W'(SRAM_DEPTH));
            dec_idx[k] = restoring ? entry[k][SRAM_INDEX-1:0]
                                   : bus.ren_addr_i[k*SRAM_INDEX +: SRAM_INDEX];
            dec_en[k]  = restoring ? lane_ok[k] : 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_WR; g++) begin : g_lane
        index_decoder #(
            .INDEX_W (SRAM_INDEX),
            .DEPTH   (SRAM_DEPTH)
        ) u_dec (
            .en_i     (dec_en[g]),
            .index_i  (dec_idx[g]),
            .onehot_o (dec_oh[g])
        );
    end

    // ---------------- write-port outputs ----------------
    logic [NUM_WR-1:0]            we_v;
    logic [NUM_WR*SRAM_DEPTH-1:0] rd_addr_v;
    logic [NUM_WR*SRAM_DEPTH-1:0] wr_addr_v;
    logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_v;

    always_comb begin
        we_v      = '0;
        rd_addr_v = '0;
        wr_addr_v = '0;
        wr_data_v = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_addr_v[k*SRAM_DEPTH +: SRAM_DEPTH] = dec_oh[k];
            if (restoring) begin
                // dec_oh is already zero for lanes past the table end
                rd_addr_v[k*SRAM_DEPTH +: SRAM_DEPTH] = dec_oh[k];
                we_v[k] = lane_ok[k];
                if (lane_ok[k]) begin
                    wr_data_v[k*SRAM_WIDTH +: SRAM_WIDTH] =
                        bus.amt_rd_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end else begin
                // rename writes in the recovery-request cycle are dropped
                we_v[k] = bus.ren_we_i[k] & ~bus.recover_i;
                wr_data_v[k*SRAM_WIDTH +: SRAM_WIDTH] =
                    bus.ren_data_i[k*SRAM_WIDTH +: SRAM_WIDTH];
            end
        end
    end

    assign bus.we_o             = we_v;
    assign bus.amt_rd_addr_o    = rd_addr_v;
    assign bus.decoded_addrwr_o = wr_addr_v;
    assign bus.datawr_o         = wr_data_v;
    assign bus.busy_o           = bus.recover_i | restoring;
    assign bus.done_o           = (state_q == ST_DONE);
    assign bus.state_o          = state_q;

    // ---------------- completed-restore counter ----------------
`ifdef RESTORE_PERF_CNT_EN
    logic [RESTORE_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if ((state_q == ST_DONE) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.restore_cnt_o = cnt_q;
`else
    assign bus.restore_cnt_o = '0;
`endif

endmodule

// File: tb/tb_map_table_restore_ctrl.sv
module tb_map_table_restore_ctrl;
    import map_restore_pkg::*;

    localparam int DEPTH = 64;
    localparam int IDX   = 6;
    localparam int WID   = 8;
    localparam int NWR   = 5;
`ifdef RESTORE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [NWR-1:0]       we;
        logic [NWR*DEPTH-1:0] dec;
        logic [NWR*WID-1:0]   data;
        logic [NWR*DEPTH-1:0] rd;
        logic                 busy;
        logic                 done;
        logic [15:0]          cnt;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    map_table_restore_ctrl_if #(
        .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(WID), .NUM_WR(NWR)
    ) bus ();

    map_table_restore_ctrl #(
        .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(WID), .NUM_WR(NWR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- environment: AMT and speculative SRAM ----------------
    logic [WID-1:0] amt      [DEPTH];
    logic [WID-1:0] spec_mem [DEPTH];

    always_comb begin
        bus.amt_rd_data_i = '0;
        for (int k = 0; k < NWR; k++)
            for (int i = 0; i < DEPTH; i++)
                if (bus.amt_rd_addr_o[k*DEPTH+i])
                    bus.amt_rd_data_i[k*WID +: WID] = bus.amt_rd_data_i[k*WID +: WID] | amt[i];
    end

    always @(posedge clk) begin
        for (int k = 0; k < NWR; k++)
            for (int i = 0; i < DEPTH; i++)
                if (bus.we_o[k] && bus.decoded_addrwr_o[k*DEPTH+i])
                    spec_mem[i] <= bus.datawr_o[k*WID +: WID];
    end

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending restore work is a list of group base entries; each restore
    // cycle consumes one. done follows the cycle that consumed the last one.
    int             grp_q[$];
    bit             m_done = 1'b0;
    int             m_cnt  = 0;
    logic [WID-1:0] exp_table [DEPTH];

    task automatic model_reset();
        grp_q.delete();
        m_done = 1'b0;
        m_cnt  = 0;
    endtask

    // observed values sampled just after the inputs settle
    logic [NWR-1:0]       obs_we;
    logic [NWR*DEPTH-1:0] obs_dec;
    logic [NWR*WID-1:0]   obs_data;
    logic                 obs_busy, obs_done;
    logic [15:0]          obs_cnt;

    // ---------------- driver ----------------
    task automatic step(input logic rec, input logic [NWR-1:0] we,
                        input logic [NWR*IDX-1:0] addr, input logic [NWR*WID-1:0] data);
        exp_t e;
        bit   restoring;
        int   ent;
        @(posedge clk);
        #1;
        bus.recover_i  = rec;
        bus.ren_we_i   = we;
        bus.ren_addr_i = addr;
        bus.ren_data_i = data;

        restoring = (grp_q.size() != 0);
        e      = '0;
        e.busy = rec | restoring;
        e.done = m_done;
        e.cnt  = PERF ? 16'(m_cnt) : 16'd0;
        if (restoring) begin
            for (int k = 0; k < NWR; k++) begin
                ent = grp_q[0] + k;
                if (ent < DEPTH) begin
                    e.we[k]             = 1'b1;
                    e.dec[k*DEPTH+ent]  = 1'b1;
                    e.rd[k*DEPTH+ent]   = 1'b1;
                    e.data[k*WID +: WID] = amt[ent];
                    exp_table[ent]      = amt[ent];
                end
            end
        end else begin
            e.data = data;
            for (int k = 0; k < NWR; k++) begin
                ent = int'(addr[k*IDX +: IDX]);
                e.dec[k*DEPTH+ent] = 1'b1;
                if (!rec && we[k]) begin
                    e.we[k]        = 1'b1;
                    exp_table[ent] = data[k*WID +: WID];
                end
            end
        end
        exp_q.push_back(e);

        if (m_done && m_cnt < 16'hFFFF) m_cnt++;
        if (restoring) void'(grp_q.pop_front());
        m_done = restoring && (grp_q.size() == 0) && !rec;
        if (rec) begin
            grp_q.delete();
            for (int b = 0; b < DEPTH; b += NWR) grp_q.push_back(b);
        end

        #1;
        obs_we   = bus.we_o;
        obs_dec  = bus.decoded_addrwr_o;
        obs_data = bus.datawr_o;
        obs_busy = bus.busy_o;
        obs_done = bus.done_o;
        obs_cnt  = bus.restore_cnt_o;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("we",   320'(bus.we_o),             320'(e.we));
                check("dec",  320'(bus.decoded_addrwr_o), 320'(e.dec));
                check("data", 320'(bus.datawr_o),         320'(e.data));
                check("rd",   320'(bus.amt_rd_addr_o),    320'(e.rd));
                check("busy", 320'(bus.busy_o),           320'(e.busy));
                check("done", 320'(bus.done_o),           320'(e.done));
                check("cnt",  320'(bus.restore_cnt_o),    320'(e.cnt));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [NWR*IDX-1:0] a;
        logic [NWR*WID-1:0] d;
        int base;

        bus.recover_i  = 1'b0;
        bus.ren_we_i   = '0;
        bus.ren_addr_i = '0;
        bus.ren_data_i = '0;
        for (int i = 0; i < DEPTH; i++) amt[i] = WID'($urandom);

        // reset state
        #1 reset = 1'b0;
        #1;
        check("rst_state", 320'(bus.state_o),       320'(ST_IDLE));
        check("rst_done",  320'(bus.done_o),        320'd0);
        check("rst_cnt",   320'(bus.restore_cnt_o), 320'd0);
        check("rst_busy",  320'(bus.busy_o),        320'd0);
        check("rst_we",    320'(bus.we_o),          320'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();

        // single rename write, lane 2 -> index 7, data 3A
        a = '0; d = '0;
        a[2*IDX +: IDX] = 6'd7;
        d[2*WID +: WID] = 8'h3A;
        step(1'b0, 5'b00100, a, d);
        check("pass_we",   320'(obs_we),                    320'(5'b00100));
        check("pass_dec2", 320'(obs_dec[2*DEPTH +: DEPTH]), 320'(64'h80));
        check("pass_dat2", 320'(obs_data[2*WID +: WID]),    320'(8'h3A));
        check("pass_busy", 320'(obs_busy),                  320'd0);

        // full restore with AMT entry i = i + 0x40
        for (int i = 0; i < DEPTH; i++) amt[i] = WID'(i + 8'h40);
        step(1'b1, '0, '0, '0);
        check("r_busy0", 320'(obs_busy), 320'd1);
        for (int c = 1; c <= 15; c++) begin
            idle();
            check("r_busy", 320'(obs_busy), 320'(c <= 13));
            check("r_done", 320'(obs_done), 320'(c == 14));
            if (c == 1) begin
                check("r_c1_we",   320'(obs_we),   320'(5'b11111));
                check("r_c1_data", 320'(obs_data), 320'(40'h4443424140));
                check("r_c1_dec0", 320'(obs_dec[0 +: DEPTH]), 320'(64'h1));
            end
            if (c == 13) begin
                check("r_c13_we",   320'(obs_we), 320'(5'b01111));
                check("r_c13_dat0", 320'(obs_data[0 +: WID]), 320'(8'h7C));
                check("r_c13_dat4", 320'(obs_data[4*WID +: WID]), 320'd0);
            end
        end
        for (int i = 0; i < DEPTH; i++)
            check("r_table", 320'(spec_mem[i]), 320'(amt[i]));

        // recover with all rename lanes writing: rename writes are dropped
        a = '0; d = '0;
        for (int k = 0; k < NWR; k++) begin
            a[k*IDX +: IDX] = IDX'(40 + k);
            d[k*WID +: WID] = 8'hEE;
        end
        step(1'b1, 5'b11111, a, d);
        check("drop_we", 320'(obs_we), 320'd0);
        idle();
        for (int k = 0; k < NWR; k++)
            check("drop_tbl", 320'(spec_mem[40+k]), 320'(8'h40 + 8'(40 + k)));
        for (int c = 2; c <= 15; c++) idle();

        // restart in cycle 6 of a restore
        step(1'b1, '0, '0, '0);
        for (int c = 1; c <= 22; c++) begin
            step(c == 6, '0, '0, '0);
            check("rs_done", 320'(obs_done), 320'(c == 20));
            if (c == 7) begin
                check("rs_c7_dec0", 320'(obs_dec[0 +: DEPTH]), 320'(64'h1));
                check("rs_c7_dec4", 320'(obs_dec[4*DEPTH +: DEPTH]), 320'(64'h10));
                check("rs_c7_we",   320'(obs_we), 320'(5'b11111));
            end
        end

        // reset in cycle 5 of a restore
        step(1'b1, '0, '0, '0);
        for (int c = 1; c <= 4; c++) idle();
        @(posedge clk);
        #1;
        bus.recover_i = 1'b0;
        bus.ren_we_i  = '0;
        reset = 1'b0;
        #1;
        check("ar_state", 320'(bus.state_o), 320'(ST_IDLE));
        check("ar_done",  320'(bus.done_o),  320'd0);
        check("ar_busy",  320'(bus.busy_o),  320'd0);
        check("ar_we",    320'(bus.we_o),    320'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;

        // three back-to-back restores (next recover in each DONE cycle)
        for (int r = 0; r < 3; r++) begin
            if (r == 0) step(1'b1, '0, '0, '0);
            for (int c = 1; c <= 14; c++) begin
                step((c == 14) && (r < 2), '0, '0, '0);
                check("bb_busy", 320'(obs_busy), 320'((c <= 13) || (r < 2)));
                check("bb_done", 320'(obs_done), 320'(c == 14));
            end
        end
        idle();
        check("bb_cnt", 320'(obs_cnt), PERF ? 320'd3 : 320'd0);

        // randomized traffic
        for (int i = 0; i < DEPTH; i++) amt[i] = WID'($urandom);
        for (int n = 0; n < 400; n++) begin
            base = $urandom_range(0, DEPTH-1);
            for (int k = 0; k < NWR; k++) begin
                a[k*IDX +: IDX] = IDX'((base + k*13) % DEPTH);
                d[k*WID +: WID] = WID'($urandom);
            end
            step($urandom_range(0, 29) == 0, NWR'($urandom), a, d);
        end
        for (int c = 0; c < 20; c++) idle();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < DEPTH; i++)
            check("final_tbl", 320'(spec_mem[i]), 320'(exp_table[i]));
        check("queue_empty", 320'(exp_q.size()), 320'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
